// File: rtl/flopr_pipe.sv
// -----------------------------------------------------------------------------
// flopr_pipe
// Elastic pipeline register: STAGES cascaded WIDTH-bit stages, each carrying a
// valid bit, with valid/ready handshakes on both ends.
//   COLLAPSE = 1 : per-stage advance, so bubbles are squeezed out under stall.
//   COLLAPSE = 0 : one global enable, so the whole pipe freezes under stall.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   flush      in   synchronous clear of every stage valid bit
//   in_valid   in   upstream beat present
//   in_ready   out  block accepts a beat this cycle
//   in_data    in   upstream payload [WIDTH-1:0]
//   out_valid  out  downstream beat present
//   out_ready  in   downstream accepts the beat
//   out_data   out  downstream payload [WIDTH-1:0]
//   occupancy  out  number of valid stages [$clog2(STAGES+1)-1:0]
// -----------------------------------------------------------------------------
module flopr_pipe #(
    parameter int               WIDTH     = 32'sd8,
    parameter int               STAGES    = 32'sd2,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter bit               COLLAPSE  = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    // Number of set bits in a stage-valid vector.
    function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] vec);
        logic [OCC_W-1:0] cnt;
        cnt = {OCC_W{1'b0}};
        for (int i = 0; i < STAGES; i++) begin
            cnt = cnt + OCC_W'(vec[i]);
        end
        return cnt;
    endfunction

    logic [STAGES-1:0] v_r;                  // stage valid bits, 0 = input side
    logic [WIDTH-1:0]  d_r     [STAGES];     // stage payload registers
    logic [STAGES-1:0] load_s;               // stage i takes its upstream neighbour this edge
    logic [STAGES-1:0] src_v_s;              // valid bit offered to stage i
    logic [WIDTH-1:0]  src_d_s [STAGES];     // payload offered to stage i
    logic              in_ready_s;

    generate
        if (COLLAPSE) begin : g_collapse
            logic [STAGES:0] adv_s;

            // Advance ripple: a stage may load when it is empty or its successor moves on.
            always_comb begin
                adv_s         = {(STAGES+1){1'b0}};
                adv_s[STAGES] = out_ready & ~flush;
                for (int i = STAGES - 1; i >= 0; i--) begin
                    adv_s[i] = ~v_r[i] | adv_s[i+1];
                end
                load_s     = adv_s[STAGES-1:0];
                // Held low while reset is asserted even though the empty pipe could advance.
                in_ready_s = adv_s[0] & ~flush & reset;
            end
        end else begin : g_global
            logic en_s;

            // Global enable: everything shifts unless the output beat is blocked.
            always_comb begin
                en_s       = ~(v_r[STAGES-1] & ~out_ready) & ~flush;
                load_s     = {STAGES{en_s}};
                in_ready_s = en_s & reset;
            end
        end
    endgenerate

    // Source selection: stage 0 is fed from the input port, stage i from stage i-1.
    always_comb begin
        src_v_s    = {STAGES{1'b0}};
        src_v_s[0] = in_valid & in_ready_s;
        src_d_s[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            src_v_s[i] = v_r[i-1];
            src_d_s[i] = d_r[i-1];
        end
    end

    // Valid-bit pipeline; flush empties every stage and overrides any movement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_r <= {STAGES{1'b0}};
        end else if (flush) begin
            v_r <= {STAGES{1'b0}};
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (load_s[i]) begin
                    v_r[i] <= src_v_s[i];
                end
            end
        end
    end

    // Payload pipeline; a register only loads when a valid beat moves into it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                d_r[i] <= RESET_VAL;
            end
        end else if (!flush) begin
            for (int i = 0; i < STAGES; i++) begin
                if (load_s[i] && src_v_s[i]) begin
                    d_r[i] <= src_d_s[i];
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = v_r[STAGES-1] & ~flush;
    assign out_data  = d_r[STAGES-1];
    assign occupancy = popcount(v_r);

endmodule

// File: tb/tb_flopr_pipe.sv
// -----------------------------------------------------------------------------
// tb_flopr_pipe
// Three instances share clk/reset: dut_c (3 stages, collapsing), dut_g
// (3 stages, global stall) and dut_s (1 stage, collapsing). A per-instance
// scoreboard queue records every accepted beat and checks every emitted beat.
// -----------------------------------------------------------------------------
module tb_flopr_pipe;

    localparam logic [7:0] RV0 = 8'h5A;
    localparam logic [7:0] RV1 = 8'hC3;
    localparam logic [7:0] RV2 = 8'h96;

    logic       clk = 1'b0;
    logic       reset;
    logic       fl   [3];
    logic       iv   [3];
    logic       ir   [3];
    logic       ov   [3];
    logic       ordy [3];
    logic [7:0] id   [3];
    logic [7:0] od   [3];
    logic [1:0] occ0, occ1;
    logic       occ_s1;
    logic [1:0] occ  [3];

    int total = 0;
    int bad   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    assign occ[0] = occ0;
    assign occ[1] = occ1;
    assign occ[2] = {1'b0, occ_s1};

    flopr_pipe #(.WIDTH(32'sd8), .STAGES(32'sd3), .RESET_VAL(RV0), .COLLAPSE(1'b1)) dut_c (
        .clk(clk), .reset(reset), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .occupancy(occ0));

    flopr_pipe #(.WIDTH(32'sd8), .STAGES(32'sd3), .RESET_VAL(RV1), .COLLAPSE(1'b0)) dut_g (
        .clk(clk), .reset(reset), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .occupancy(occ1));

    flopr_pipe #(.WIDTH(32'sd8), .STAGES(32'sd1), .RESET_VAL(RV2), .COLLAPSE(1'b1)) dut_s (
        .clk(clk), .reset(reset), .flush(fl[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(id[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
        .occupancy(occ_s1));

    // ---------------- scoreboard queue access ----------------
    function automatic int q_size(input int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic q_push(input int k, input logic [7:0] val);
        case (k)
            0:       q0.push_back(val);
            1:       q1.push_back(val);
            default: q2.push_back(val);
        endcase
    endtask

    task automatic q_pop(input int k, output logic [7:0] val);
        case (k)
            0:       val = q0.pop_front();
            1:       val = q1.pop_front();
            default: val = q2.pop_front();
        endcase
    endtask

    task automatic q_clear_all();
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    // Runs mid-cycle: handshakes seen here complete on the coming rising edge.
    task automatic monitor();
        logic [7:0] exp_v;
        for (int k = 0; k < 3; k++) begin
            if (!reset || fl[k]) begin
                case (k)
                    0:       q0.delete();
                    1:       q1.delete();
                    default: q2.delete();
                endcase
            end else begin
                if (ov[k] && ordy[k]) begin
                    total++;
                    if (q_size(k) == 0) begin
                        bad++;
                        $display("FAIL sb_extra[%0d]: got beat %h, expected no beat", k, od[k]);
                    end else begin
                        q_pop(k, exp_v);
                        if (od[k] !== exp_v) begin
                            bad++;
                            $display("FAIL sb_data[%0d]: got %h, expected %h", k, od[k], exp_v);
                        end
                    end
                end
                if (iv[k] && ir[k]) q_push(k, id[k]);
            end
        end
    endtask

    // One clock: monitor mid-cycle, then return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    // Empty every instance with out_ready high; bounded, checks are done by callers.
    task automatic drain_all();
        int n;
        for (int k = 0; k < 3; k++) begin
            ordy[k] = 1'b1;
            iv[k]   = 1'b0;
        end
        n = 0;
        while ((occ[0] != 2'd0 || occ[1] != 2'd0 || occ[2] != 2'd0) && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 3; k++) ordy[k] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] rv [3];
        rv[0] = RV0; rv[1] = RV1; rv[2] = RV2;
        for (int k = 0; k < 3; k++) ordy[k] = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            total += 4;
            if (ov[k] !== 1'b0) begin bad++; $display("FAIL reset_out_valid[%0d]: got %b, expected 0", k, ov[k]); end
            if (occ[k] !== 2'd0) begin bad++; $display("FAIL reset_occupancy[%0d]: got %0d, expected 0", k, occ[k]); end
            if (od[k] !== rv[k]) begin bad++; $display("FAIL reset_out_data[%0d]: got %h, expected %h", k, od[k], rv[k]); end
            if (ir[k] !== 1'b0) begin bad++; $display("FAIL reset_in_ready[%0d]: got %b, expected 0", k, ir[k]); end
            ordy[k] = 1'b0;
        end
    endtask

    task automatic test_streaming();
        logic exp_v;
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 2; k++) begin
                iv[k]   = (c < 5);
                id[k]   = 8'(c + 1);
                ordy[k] = 1'b1;
            end
            #1;
            if (c < 5) begin
                for (int k = 0; k < 2; k++) begin
                    total++;
                    if (ir[k] !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] c=%0d: got %b, expected 1", k, c, ir[k]); end
                end
            end
            tick();
            exp_v = (c >= 2 && c < 7);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (ov[k] !== exp_v) begin bad++; $display("FAIL stream_out_valid[%0d] c=%0d: got %b, expected %b", k, c, ov[k], exp_v); end
                if (exp_v) begin
                    total++;
                    if (od[k] !== 8'(c - 1)) begin bad++; $display("FAIL stream_out_data[%0d] c=%0d: got %h, expected %h", k, c, od[k], 8'(c - 1)); end
                end
            end
        end
        for (int k = 0; k < 2; k++) begin iv[k] = 1'b0; ordy[k] = 1'b0; end
    endtask

    task automatic test_backpressure();
        int acc [2];
        acc[0] = 0; acc[1] = 0;
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 2; k++) begin
                ordy[k] = 1'b0;
                iv[k]   = 1'b1;
                id[k]   = 8'h10 + 8'(acc[k]);
            end
            #1;
            for (int k = 0; k < 2; k++) if (ir[k]) acc[k]++;
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0;
            total += 3;
            if (acc[k] != 3) begin bad++; $display("FAIL bp_accepted[%0d]: got %0d, expected 3", k, acc[k]); end
            if (occ[k] !== 2'd3) begin bad++; $display("FAIL bp_occupancy[%0d]: got %0d, expected 3", k, occ[k]); end
            if (ir[k] !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b, expected 0", k, ir[k]); end
        end
        drain_all();
        for (int k = 0; k < 2; k++) begin
            total += 3;
            if (occ[k] !== 2'd0) begin bad++; $display("FAIL bp_drain[%0d]: occupancy %0d, expected 0", k, occ[k]); end
            if (q_size(k) != 0) begin bad++; $display("FAIL bp_lost[%0d]: %0d beats outstanding, expected 0", k, q_size(k)); end
            if (od[k] !== 8'h12) begin bad++; $display("FAIL bp_last[%0d]: got %h, expected 12", k, od[k]); end
        end
    endtask

    task automatic test_bubble();
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 2; k++) begin
                ordy[k] = 1'b0;
                iv[k]   = (c == 0 || c == 2);
                id[k]   = (c == 0) ? 8'hAA : 8'hBB;
            end
            tick();
            total++;
            if (ir[0] !== 1'b1) begin bad++; $display("FAIL bubble_c_in_ready c=%0d: got %b, expected 1", c, ir[0]); end
            if (c == 2) begin
                total++;
                if (ir[1] !== 1'b0) begin bad++; $display("FAIL bubble_g_in_ready: got %b, expected 0", ir[1]); end
            end
        end
        total += 7;
        if (occ[0] !== 2'd2) begin bad++; $display("FAIL bubble_c_occupancy: got %0d, expected 2", occ[0]); end
        if (ir[0] !== 1'b1) begin bad++; $display("FAIL bubble_c_packed_ready: got %b, expected 1", ir[0]); end
        if (ov[0] !== 1'b1 || od[0] !== 8'hAA) begin bad++; $display("FAIL bubble_c_head: got %b/%h, expected 1/aa", ov[0], od[0]); end
        if (occ[1] !== 2'd2) begin bad++; $display("FAIL bubble_g_occupancy: got %0d, expected 2", occ[1]); end
        if (ir[1] !== 1'b0) begin bad++; $display("FAIL bubble_g_frozen: got %b, expected 0", ir[1]); end
        if (od[1] !== 8'hAA) begin bad++; $display("FAIL bubble_g_head: got %h, expected aa", od[1]); end
        if (q_size(0) != 2) begin bad++; $display("FAIL bubble_c_accepted: got %0d, expected 2", q_size(0)); end
        drain_all();
        for (int k = 0; k < 2; k++) begin
            total += 2;
            if (q_size(k) != 0) begin bad++; $display("FAIL bubble_lost[%0d]: %0d outstanding, expected 0", k, q_size(k)); end
            if (od[k] !== 8'hBB) begin bad++; $display("FAIL bubble_last[%0d]: got %h, expected bb", k, od[k]); end
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 2; k++) begin
                ordy[k] = 1'b0;
                iv[k]   = 1'b1;
                id[k]   = 8'h40 + 8'(c);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (occ[k] !== 2'd3) begin bad++; $display("FAIL flush_fill[%0d]: got %0d, expected 3", k, occ[k]); end
            fl[k] = 1'b1; ordy[k] = 1'b1; iv[k] = 1'b1; id[k] = 8'hEE;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            total += 2;
            if (ov[k] !== 1'b0) begin bad++; $display("FAIL flush_out_valid[%0d]: got %b, expected 0", k, ov[k]); end
            if (ir[k] !== 1'b0) begin bad++; $display("FAIL flush_in_ready[%0d]: got %b, expected 0", k, ir[k]); end
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            fl[k] = 1'b0; iv[k] = 1'b0;
            total++;
            if (occ[k] !== 2'd0) begin bad++; $display("FAIL flush_occupancy[%0d]: got %0d, expected 0", k, occ[k]); end
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (ov[k] !== 1'b0) begin bad++; $display("FAIL flush_ghost[%0d] c=%0d: got out_valid %b, expected 0", k, c, ov[k]); end
            end
        end
        for (int k = 0; k < 2; k++) ordy[k] = 1'b0;
    endtask

    task automatic test_single();
        ordy[2] = 1'b0; iv[2] = 1'b1; id[2] = 8'h11;
        tick();
        total++;
        if (occ[2] !== 2'd1) begin bad++; $display("FAIL single_fill: occupancy %0d, expected 1", occ[2]); end
        ordy[2] = 1'b1; id[2] = 8'h3C;
        #1;
        total++;
        if (ir[2] !== 1'b1) begin bad++; $display("FAIL single_in_ready: got %b, expected 1", ir[2]); end
        tick();
        iv[2] = 1'b0;
        total += 2;
        if (occ[2] !== 2'd1) begin bad++; $display("FAIL single_occupancy: got %0d, expected 1", occ[2]); end
        if (ov[2] !== 1'b1 || od[2] !== 8'h3C) begin bad++; $display("FAIL single_swap: got %b/%h, expected 1/3c", ov[2], od[2]); end
        tick();
        ordy[2] = 1'b0;
        total += 3;
        if (occ[2] !== 2'd0) begin bad++; $display("FAIL single_drain: occupancy %0d, expected 0", occ[2]); end
        if (od[2] !== 8'h3C) begin bad++; $display("FAIL single_hold: got %h, expected 3c", od[2]); end
        if (q_size(2) != 0) begin bad++; $display("FAIL single_lost: %0d outstanding, expected 0", q_size(2)); end
    endtask

    task automatic test_reset_midstream();
        for (int c = 0; c < 3; c++) begin
            ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 8'h71 + 8'(c);
            tick();
        end
        iv[0] = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        total += 4;
        if (ov[0] !== 1'b0) begin bad++; $display("FAIL mid_reset_out_valid: got %b, expected 0", ov[0]); end
        if (occ[0] !== 2'd0) begin bad++; $display("FAIL mid_reset_occupancy: got %0d, expected 0", occ[0]); end
        if (od[0] !== RV0) begin bad++; $display("FAIL mid_reset_out_data: got %h, expected %h", od[0], RV0); end
        if (ir[0] !== 1'b0) begin bad++; $display("FAIL mid_reset_in_ready: got %b, expected 0", ir[0]); end
        q_clear_all();
        tick();
        reset = 1'b1;
        ordy[0] = 1'b1; iv[0] = 1'b1; id[0] = 8'hA5;
        tick();
        iv[0] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            total++;
            if (c < 3) begin
                if (ov[0] !== 1'b0) begin bad++; $display("FAIL mid_restart_early c=%0d: got out_valid %b, expected 0", c, ov[0]); end
                tick();
            end else begin
                if (ov[0] !== 1'b1 || od[0] !== 8'hA5) begin bad++; $display("FAIL mid_restart_out: got %b/%h, expected 1/a5", ov[0], od[0]); end
            end
        end
        tick();
        total++;
        if (occ[0] !== 2'd0 || q_size(0) != 0) begin bad++; $display("FAIL mid_restart_drain: occupancy %0d outstanding %0d, expected 0/0", occ[0], q_size(0)); end
        ordy[0] = 1'b0;
    endtask

    // Watchdog: stop the run if something wedges beyond any sane duration.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Test sequence.
    initial begin
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fl[k] = 1'b0; iv[k] = 1'b0; ordy[k] = 1'b0; id[k] = 8'h00;
        end
        #1;
        reset = 1'b0;
        #1;
        test_reset();
        tick();
        reset = 1'b1;
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
        test_single();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
